usb_send_fifo_gated: RTL and testbench

- Parametrised device-to-host send buffer placed between user logic and a usbfs_core_top IN endpoint (epXX_data/valid/ready).
- Generalises the fixed 8-bit, 1024-deep per-channel send buffer in width and depth, and adds the following:
  - a release gate that holds bytes until a threshold or a timeout is reached, so the host sees fuller packets;
  - a synchronous clear;
  - an occupancy output.
- One instance per CDC channel.

---
 rtl/usb_send_fifo_gated_if.sv | 25 ++
 rtl/usb_send_fifo_gated.sv | 151 +++++++++++++++
 tb/tb_usb_send_fifo_gated.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_send_fifo_gated_if.sv
// Handshake bundle between user logic, the gated send FIFO and a usbfs IN endpoint.
interface usb_send_fifo_gated_if #(
    parameter int DWIDTH = 8,
    parameter int ASIZE  = 10
);
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ASIZE:0]    level;
    logic              holding;
    logic              almost_full;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level, holding, almost_full
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level, holding, almost_full
    );
endinterface

// File: rtl/usb_send_fifo_gated.sv
// Device-to-host send FIFO with a release gate (threshold / timeout / flush) in front of a usbfs IN endpoint.
// Optional registered almost_full output enabled by defining USB_SEND_FIFO_AFULL_EN.
module usb_send_fifo_gated #(
    parameter int DWIDTH  = 8,
    parameter int ASIZE   = 10,
    parameter int THRESH  = 32,
    parameter int TIMEOUT = 60000,
    parameter int AFULL   = (1 << ASIZE) - 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 flush,
    usb_send_fifo_gated_if.slave bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ASIZE:0]  THR   = (ASIZE+1)'(THRESH);
    localparam logic [ASIZE:0]  P_ONE = (ASIZE+1)'(1);
    localparam logic [TW-1:0]   T_ONE = TW'(1);
    localparam logic [TW-1:0]   TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    if (ASIZE < 2 || ASIZE > 14 || THRESH < 1 || THRESH > DEPTH || TIMEOUT < 0 || AFULL > DEPTH)
    begin : g_param_check
        $error("usb_send_fifo_gated: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rdata_q;
    logic [DWIDTH-1:0] out_data_q;

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] raddr_q, raddr_d;
    logic [ASIZE:0] level_q, level_d;
    logic           rd_v_q, rd_v_d;
    logic           out_valid_q, out_valid_d;
    logic [TW-1:0]  timer_q, timer_d;
    state_t         state_q, state_d;

    logic full, wr_en, out_hs, load, issue;

    // rptr only retires on the output handshake, so the words sitting in the
    // read register and output register still occupy memory slots; raddr is
    // the prefetch pointer that runs ahead of it.
    assign full   = (wptr_q ^ rptr_q) == {1'b1, {ASIZE{1'b0}}};
    assign wr_en  = bus.in_valid && !full && !clear;
    assign out_hs = out_valid_q && bus.out_ready;
    assign load   = rd_v_q && (!out_valid_q || bus.out_ready);
    assign issue  = (state_q == DRAIN) && (raddr_q != wptr_q) && (!rd_v_q || load);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        raddr_d     = raddr_q;
        level_d     = level_q;
        rd_v_d      = rd_v_q;
        out_valid_d = out_valid_q;
        if (wr_en)  wptr_d  = wptr_q + P_ONE;
        if (out_hs) rptr_d  = rptr_q + P_ONE;
        if (issue)  raddr_d = raddr_q + P_ONE;
        case ({wr_en, out_hs})
            2'b10:   level_d = level_q + P_ONE;
            2'b01:   level_d = level_q - P_ONE;
            default: level_d = level_q;
        endcase
        if (issue)     rd_v_d = 1'b1;
        else if (load) rd_v_d = 1'b0;
        if (load)        out_valid_d = 1'b1;
        else if (out_hs) out_valid_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (TIMEOUT == 0 || level_d >= THR) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = HOLD;
                        timer_d = '0;
                    end
                end
            end
            HOLD: begin
                if (timer_q != TMAX) timer_d = timer_q + T_ONE;
                if (level_d >= THR || timer_q == TLAST || flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (level_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            raddr_q     <= '0;
            level_q     <= '0;
            rd_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= IDLE;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            raddr_q     <= raddr_d;
            level_q     <= level_d;
            rd_v_q      <= rd_v_d;
            out_valid_q <= out_valid_d;
            timer_q     <= timer_d;
            state_q     <= state_d;
        end
    end

    // Storage and data registers carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[ASIZE-1:0]] <= bus.in_data;
        if (issue) rdata_q <= mem[raddr_q[ASIZE-1:0]];
        if (load)  out_data_q <= rdata_q;
    end

    assign bus.in_ready  = !full;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.level     = level_q;
    assign bus.holding   = (state_q == HOLD);

`ifdef USB_SEND_FIFO_AFULL_EN
    localparam logic [ASIZE:0] AF = (ASIZE+1)'(AFULL);
    logic afull_q;

    always_ff @(posedge clk) begin
        if (!rstn || clear) afull_q <= 1'b0;
        else                afull_q <= (level_d >= AF);
    end

    assign bus.almost_full = afull_q;
`else
    assign bus.almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_usb_send_fifo_gated.sv
// Directed bench for usb_send_fifo_gated: gated instance (THRESH=4, TIMEOUT=16) plus ungated instance (TIMEOUT=0, AFULL=12).
module tb_usb_send_fifo_gated;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear_g = 1'b0;
    logic flush_g = 1'b0;
    logic clear_n = 1'b0;
    logic flush_n = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    usb_send_fifo_gated_if #(.DWIDTH(8), .ASIZE(4)) bus_g ();
    usb_send_fifo_gated_if #(.DWIDTH(8), .ASIZE(4)) bus_n ();

    usb_send_fifo_gated #(
        .DWIDTH(8), .ASIZE(4), .THRESH(4), .TIMEOUT(16), .AFULL(12)
    ) u_dut (
        .clk(clk), .rstn(rstn), .clear(clear_g), .flush(flush_g), .bus(bus_g)
    );

    usb_send_fifo_gated #(
        .DWIDTH(8), .ASIZE(4), .THRESH(4), .TIMEOUT(0), .AFULL(12)
    ) u_nogate (
        .clk(clk), .rstn(rstn), .clear(clear_n), .flush(flush_n), .bus(bus_n)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_lvl;
        logic       e_hold;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for a word on the gated DUT, checks it, and consumes it (out_ready held 1).
    task automatic expect_word(input string nm, input int exp);
        int n = 0;
        while (!bus_g.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_valid"}, int'(bus_g.out_valid), 1);
        check({nm, "_data"}, int'(bus_g.out_data), exp);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold_cnt;
        int qd [$];
        logic acc, hs;

        bus_g.in_valid = 1'b0; bus_g.in_data = '0; bus_g.out_ready = 1'b1;
        bus_n.in_valid = 1'b0; bus_n.in_data = '0; bus_n.out_ready = 1'b0;

        // Threshold release: four back-to-back writes, drain with out_ready=1.
        vecs[0] = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1};
        vecs[1] = '{1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 8'h00, 2, 1'b1};
        vecs[2] = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 8'h00, 3, 1'b1};
        vecs[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h41, 4, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h42, 3, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h43, 2, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0};

        rstn = 1'b0;
        tick();
        tick();
        check("rst_level",  int'(bus_g.level), 0);
        check("rst_ovalid", int'(bus_g.out_valid), 0);
        check("rst_iready", int'(bus_g.in_ready), 1);
        check("rst_hold",   int'(bus_g.holding), 0);
        check("rst_afull",  int'(bus_g.almost_full), 0);
        check("rst_n_level", int'(bus_n.level), 0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus_g.in_valid  = vecs[i].iv;
            bus_g.in_data   = vecs[i].d;
            bus_g.out_ready = vecs[i].ordy;
            tick();
            check($sformatf("vec%0d_iready", i), int'(bus_g.in_ready), int'(vecs[i].e_ir));
            check($sformatf("vec%0d_ovalid", i), int'(bus_g.out_valid), int'(vecs[i].e_ov));
            check($sformatf("vec%0d_level", i), int'(bus_g.level), vecs[i].e_lvl);
            check($sformatf("vec%0d_hold", i), int'(bus_g.holding), int'(vecs[i].e_hold));
            if (vecs[i].e_ov)
                check($sformatf("vec%0d_odata", i), int'(bus_g.out_data), int'(vecs[i].e_od));
        end

        // Timeout release: three bytes held for the full timeout window.
        hold_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            bus_g.in_valid = (i < 3);
            bus_g.in_data  = 8'(8'h11 * (i + 1));
            tick();
            if (bus_g.holding && !bus_g.out_valid) hold_cnt++;
        end
        bus_g.in_valid = 1'b0;
        check("tmo_hold_cycles", hold_cnt, 16);
        tick();
        check("tmo_release", int'(bus_g.holding), 0);
        expect_word("tmo_w0", 8'h11);
        expect_word("tmo_w1", 8'h22);
        expect_word("tmo_w2", 8'h33);
        check("tmo_level_end", int'(bus_g.level), 0);

        // Full: 16 words stalled, 17th refused until one word leaves.
        bus_g.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_g.in_valid = 1'b1;
            bus_g.in_data  = 8'(i);
            tick();
        end
        check("full_level", int'(bus_g.level), 16);
        check("full_iready", int'(bus_g.in_ready), 0);
        bus_g.in_data = 8'hA5;
        tick();
        check("full_refused_level", int'(bus_g.level), 16);
        bus_g.out_ready = 1'b1;
        tick();
        bus_g.out_ready = 1'b0;
        check("full_pop_level", int'(bus_g.level), 15);
        check("full_pop_iready", int'(bus_g.in_ready), 1);
        tick();
        bus_g.in_valid = 1'b0;
        check("full_a5_level", int'(bus_g.level), 16);
        bus_g.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) expect_word($sformatf("full_w%0d", i), i);
        expect_word("full_wA5", 8'hA5);
        check("full_level_end", int'(bus_g.level), 0);

        // Flush: two held bytes released early.
        for (int i = 0; i < 5; i++) begin
            bus_g.in_valid = (i < 2);
            bus_g.in_data  = 8'(8'h61 + i);
            tick();
        end
        bus_g.in_valid = 1'b0;
        check("flush_pre_hold", int'(bus_g.holding), 1);
        flush_g = 1'b1;
        tick();
        flush_g = 1'b0;
        check("flush_hold_drop", int'(bus_g.holding), 0);
        tick();
        tick();
        check("flush_ovalid", int'(bus_g.out_valid), 1);
        expect_word("flush_w0", 8'h61);
        expect_word("flush_w1", 8'h62);

        // Clear mid-handshake, with a competing write in the same cycle.
        bus_g.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_g.in_valid = 1'b1;
            bus_g.in_data  = 8'(8'hC0 + i);
            tick();
        end
        bus_g.in_valid = 1'b0;
        tick();
        check("clr_pre_level", int'(bus_g.level), 6);
        check("clr_pre_ovalid", int'(bus_g.out_valid), 1);
        clear_g = 1'b1;
        bus_g.in_valid = 1'b1;
        bus_g.in_data  = 8'hEE;
        tick();
        clear_g = 1'b0;
        bus_g.in_valid = 1'b0;
        check("clr_level", int'(bus_g.level), 0);
        check("clr_ovalid", int'(bus_g.out_valid), 0);
        check("clr_iready", int'(bus_g.in_ready), 1);
        check("clr_hold", int'(bus_g.holding), 0);
        bus_g.in_valid = 1'b1;
        bus_g.in_data  = 8'h5A;
        tick();
        bus_g.in_valid  = 1'b0;
        bus_g.out_ready = 1'b1;
        expect_word("clr_first", 8'h5A);
        check("clr_level_end", int'(bus_g.level), 0);

        // Ungated instance: random traffic against a queue model.
        for (int c = 0; c < 10000; c++) begin
            bus_n.in_valid  = ($urandom_range(0, 3) != 0);
            bus_n.in_data   = 8'($urandom_range(0, 255));
            bus_n.out_ready = (c % 1000 < 500) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 3) != 0);
            #1;
            acc = bus_n.in_valid && bus_n.in_ready;
            hs  = bus_n.out_valid && bus_n.out_ready;
            if (hs) begin
                if (qd.size() == 0) begin
                    check("rnd_spurious_valid", int'(bus_n.out_valid), 0);
                end else begin
                    check("rnd_data", int'(bus_n.out_data), qd[0]);
                    void'(qd.pop_front());
                end
            end
            if (acc) qd.push_back(int'(bus_n.in_data));
            tick();
            check("rnd_level", int'(bus_n.level), qd.size());
            check("rnd_iready", int'(bus_n.in_ready), int'(qd.size() < 16));
            check("rnd_hold", int'(bus_n.holding), 0);
`ifdef USB_SEND_FIFO_AFULL_EN
            check("rnd_afull", int'(bus_n.almost_full), int'(qd.size() >= 12));
`else
            check("rnd_afull", int'(bus_n.almost_full), 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
